acc_cpu_core: RTL and testbench
===============================

ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter: DATA_W, 8, accumulator/instruction/memory data width; legal 6..32.
REQ-002 Parameter: ADDR_W, 5, PC and memory address width; SHALL satisfy ADDR_W <= DATA_W-3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start request; sampled only in IDLE.
REQ-006 mem_req  output  1  memory request; held until ack.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-008 mem_addr  output  ADDR_W  request address; valid while mem_req.
REQ-009 mem_wdata  output  DATA_W  write data (= AC); valid while mem_req and mem_we.
REQ-010 mem_rdata  input  DATA_W  read data; valid in the ack cycle.
REQ-011 mem_ack  input  1  completes the current request in the cycle it is high with mem_req.
REQ-012 ac_out  output  DATA_W  accumulator value.
REQ-013 pc_out  output  ADDR_W  program counter value.
REQ-014 flag_z, flag_c  output  1 each  zero flag; carry/borrow flag.
REQ-015 halted  output  1  high while in HALTED state.

Function
REQ-016 Instruction: opcode = ir[DATA_W-1:DATA_W-3]; operand address = ir[ADDR_W-1:0]; other bits ignored.
REQ-017 Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JZ, 110 NOP, 111 HALT.
REQ-018 States: IDLE, FETCH, DECODE, EXEC, HALTED; IDLE -> FETCH on run=1.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on ack: IR<=mem_rdata, PC<=PC+1 modulo 2^ADDR_W, -> DECODE.
REQ-020 DECODE (exactly 1 cycle, mem_req=0): JMP: PC<=operand, -> FETCH; JZ: PC<=operand if flag_z else unchanged, -> FETCH; NOP -> FETCH; HALT -> HALTED; LDA/STA/ADD/SUB -> EXEC.
REQ-021 EXEC: mem_req=1, mem_addr=operand, mem_we=1 only for STA, mem_wdata=AC; on ack -> FETCH.
REQ-022 On EXEC ack: LDA AC<=rdata; ADD AC<=AC+rdata, flag_c<=carry out; SUB AC<=AC-rdata, flag_c<=borrow (1 when rdata>AC unsigned); STA no register change.
REQ-023 flag_z SHALL update to (new AC==0) on LDA/ADD/SUB only; flag_c unchanged by LDA/STA.
REQ-024 While mem_req=1 and mem_ack=0, mem_addr/mem_we/mem_wdata and all registers SHALL hold; zero-wait (ack in first req cycle) SHALL be supported.
REQ-025 mem_ack while mem_req=0 SHALL be ignored.
REQ-026 HALTED is sticky until rst_n; run ignored outside IDLE.
REQ-027 Minimum cycles per instruction: 2 (JMP/JZ/NOP/HALT), 3 (memory ops) with zero-wait memory.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, PC=0, IR=0, AC=0, flag_z=1, flag_c=0, mem_req=0, mem_we=0, halted=0.
REQ-029 Reset asserted mid-request SHALL drop mem_req asynchronously; the pending transfer is abandoned and has no architectural effect.

Structure
REQ-030 Package acc_cpu_pkg SHALL hold the opcode enumeration and state enumeration.
REQ-031 One sub-module acc_cpu_alu (combinational pass/add/sub with carry/borrow, DATA_W-parametrised) SHALL be instantiated; FSM and registers in acc_cpu_core.

Verification (DATA_W=8, ADDR_W=5)
REQ-032 Program mem[0..3]=0x0A,0x4B,0x2C,0xE0, mem[10]=0x05, mem[11]=0x03, run pulse -> mem[12]=0x08, ac_out=0x08, flag_z=0, pc_out=4, halted=1.
REQ-033 LDA 0xFF then ADD 0x01 -> ac_out=0x00, flag_c=1, flag_z=1; then SUB 0x01 -> ac_out=0xFF, flag_c=1, flag_z=0.
REQ-034 JZ with flag_z=1 to 7 -> next fetch addr 7; with flag_z=0 -> next fetch addr = JZ address+1.
REQ-035 JMP 31 (0x9F), mem[31]=0xC0 (NOP) -> fetch after NOP at mem_addr 0 (PC wrap).
REQ-036 mem_ack delayed 3 cycles in FETCH and EXEC -> mem_req, mem_addr, mem_we, mem_wdata, ac_out, pc_out stable until ack; result identical to zero-wait run.
REQ-037 rst_n low during EXEC of STA before ack -> mem_req=0 same cycle, pc_out=0, ac_out=0, flag_z=1, no write completes.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states and ALU operations.
package acc_cpu_pkg;

  // Opcode field width, taken from the top of the instruction word.
  localparam int unsigned OpW = 3;

  typedef enum logic [OpW-1:0] {
    OpLda  = 3'b000,
    OpSta  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpJmp  = 3'b100,
    OpJz   = 3'b101,
    OpNop  = 3'b110,
    OpHalt = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalted
  } state_e;

  typedef enum logic [1:0] {
    AluPass,
    AluAdd,
    AluSub
  } alu_op_e;

  // Memory-operand instructions map onto an ALU operation; everything else passes.
  function automatic alu_op_e alu_op_for(opcode_e op);
    unique case (op)
      OpAdd:   return AluAdd;
      OpSub:   return AluSub;
      default: return AluPass;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: pass-through, add with carry out, subtract with borrow out.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra top bit carries out of the add, and is set on borrow (b > a) for the subtract.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select result and carry/borrow by operation.
  always_comb begin
    result = b;
    carry  = 1'b0;
    unique case (op)
      AluAdd:  {carry, result} = sum;
      AluSub:  {carry, result} = diff;
      default: begin
        result = b;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: fetch / decode / execute over a req/ack memory port.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  state_e            state_q, state_d;
  // IR is kept as its two meaningful fields; the bits between them are never used.
  opcode_e           op_q, op_d;
  logic [ADDR_W-1:0] opnd_q, opnd_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (ac_q),
    .b      (mem_rdata),
    .op     (alu_op_for(op_q)),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // State and architectural registers; async reset also drops mem_req at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpLda;
      opnd_q  <= '0;
      pc_q    <= '0;
      ac_q    <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  if (mem_ack) state_d = StDecode;
      StDecode: begin
        unique case (op_q)
          OpJmp, OpJz, OpNop: state_d = StFetch;
          OpHalt:             state_d = StHalted;
          default:            state_d = StExec;
        endcase
      end
      StExec:   if (mem_ack) state_d = StFetch;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath updates; mem_req is high in FETCH/EXEC, so mem_ack alone marks completion there.
  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    pc_d   = pc_q;
    ac_d   = ac_q;
    z_d    = z_q;
    c_d    = c_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ack) begin
          op_d   = opcode_e'(mem_rdata[DATA_W-1 -: OpW]);
          opnd_d = mem_rdata[ADDR_W-1:0];
          pc_d   = pc_q + 1'b1;
        end
      end
      StDecode: begin
        if (op_q == OpJmp || (op_q == OpJz && z_q)) pc_d = opnd_q;
      end
      StExec: begin
        if (mem_ack && op_q != OpSta) begin
          ac_d = alu_result;
          z_d  = (alu_result == '0);
          if (op_q inside {OpAdd, OpSub}) c_d = alu_carry;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Moore outputs decoded from the current state and registers.
  always_comb begin
    mem_req   = (state_q == StFetch) || (state_q == StExec);
    mem_we    = (state_q == StExec) && (op_q == OpSta);
    mem_addr  = (state_q == StExec) ? opnd_q : pc_q;
    mem_wdata = ac_q;
    halted    = (state_q == StHalted);
  end

  assign ac_out = ac_q;
  assign pc_out = pc_q;
  assign flag_z = z_q;
  assign flag_c = c_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: directed programs plus random forward-only programs,
// checked against an instruction-level model of the accumulator machine.
module tb_acc_cpu_core;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int MEM = 32;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] ac_out;
  logic [AW-1:0] pc_out;
  logic          flag_z;
  logic          flag_c;
  logic          halted;

  acc_cpu_core #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ac_out    (ac_out),
    .pc_out    (pc_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model state.
  logic [7:0] mem [MEM];
  logic [7:0] img [MEM];
  logic       do_load;
  int         hs_cnt;
  int         ack_delay;
  bit         ack_rand;
  bit         stray_en;

  // Posedge side: image load, completed handshakes and writes.
  initial begin
    hs_cnt = 0;
    forever begin
      @(posedge clk);
      if (do_load) begin
        for (int i = 0; i < MEM; i++) mem[i] = img[i];
        hs_cnt = 0;
      end else if (mem_req && mem_ack) begin
        hs_cnt = hs_cnt + 1;
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Negedge side: ack after a per-request delay, optional stray acks while idle.
  initial begin
    int  wait_cnt;
    int  cur_delay;
    int  seen_hs;
    bit  in_req;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    cur_delay = 0;
    seen_hs   = 0;
    in_req    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        in_req  = 1'b0;
        seen_hs = hs_cnt;
      end else begin
        if (hs_cnt != seen_hs) begin
          seen_hs = hs_cnt;
          in_req  = 1'b0;
        end
        if (mem_req) begin
          if (!in_req) begin
            in_req    = 1'b1;
            wait_cnt  = 0;
            cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
          end
          if (wait_cnt >= cur_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            wait_cnt++;
          end
        end else begin
          in_req    = 1'b0;
          mem_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // Instruction-level reference model.
  typedef struct {
    bit we;
    int addr;
    int wdata;
    int pc;
    int ac;
  } acc_t;

  acc_t exp_q[$];
  int   exp_ac, exp_z, exp_c, exp_pc, exp_cycles;
  bit   exp_halt;
  int   exp_mem [MEM];

  function automatic void model_run(int max_instr);
    int pc, ac, z, c, w, op, a;
    pc = 0; ac = 0; z = 1; c = 0;
    exp_q.delete();
    exp_cycles = 0;
    exp_halt   = 1'b0;
    for (int i = 0; i < MEM; i++) exp_mem[i] = int'(img[i]);
    for (int n = 0; n < max_instr && !exp_halt; n++) begin
      w = exp_mem[pc];
      exp_q.push_back('{1'b0, pc, 0, pc, ac});
      pc = (pc + 1) % MEM;
      op = w / 32;
      a  = w % 32;
      case (op)
        0: begin
          exp_q.push_back('{1'b0, a, 0, pc, ac});
          ac = exp_mem[a];
          z  = (ac == 0);
        end
        1: begin
          exp_q.push_back('{1'b1, a, ac, pc, ac});
          exp_mem[a] = ac;
        end
        2: begin
          exp_q.push_back('{1'b0, a, 0, pc, ac});
          ac = ac + exp_mem[a];
          c  = (ac > 255);
          ac = ac % 256;
          z  = (ac == 0);
        end
        3: begin
          exp_q.push_back('{1'b0, a, 0, pc, ac});
          c  = (exp_mem[a] > ac);
          ac = (ac - exp_mem[a] + 256) % 256;
          z  = (ac == 0);
        end
        4: pc = a;
        5: if (z != 0) pc = a;
        6: ;
        default: exp_halt = 1'b1;
      endcase
      exp_cycles += (op < 4) ? 3 : 2;
    end
    exp_ac = ac;
    exp_z  = z;
    exp_c  = c;
    exp_pc = pc;
  endfunction

  int n_checks;
  int n_fail;
  int obs_addr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse run, then track every access against the model until halt or budget.
  task automatic run_prog(input int max_cycles, input bit expect_halt, input bit chk_cycles);
    int cycles;
    int idx;
    int last_idx;
    cycles   = 0;
    last_idx = -1;
    obs_addr.delete();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    while (!halted && cycles < max_cycles) begin
      if (mem_req) begin
        idx = hs_cnt;
        check("access_in_model", 32'(idx < exp_q.size()), 32'd1);
        if (idx < exp_q.size()) begin
          if (idx != last_idx) begin
            obs_addr.push_back(int'(mem_addr));
            last_idx = idx;
          end
          check("mem_addr", 32'(mem_addr), 32'(exp_q[idx].addr));
          check("mem_we", 32'(mem_we), 32'(exp_q[idx].we));
          if (exp_q[idx].we) check("mem_wdata", 32'(mem_wdata), 32'(exp_q[idx].wdata));
          check("ac_hold", 32'(ac_out), 32'(exp_q[idx].ac));
          check("pc_hold", 32'(pc_out), 32'(exp_q[idx].pc));
        end
      end
      @(negedge clk);
      cycles++;
    end
    if (expect_halt) begin
      check("halted", 32'(halted), 32'd1);
      check("access_count", 32'(hs_cnt), 32'(exp_q.size()));
      check("ac_out", 32'(ac_out), 32'(exp_ac));
      check("flag_z", 32'(flag_z), 32'(exp_z));
      check("flag_c", 32'(flag_c), 32'(exp_c));
      check("pc_out", 32'(pc_out), 32'(exp_pc));
      if (chk_cycles)
        check("cycles", 32'(cycles), 32'(exp_cycles + (ack_rand ? 0 : ack_delay) * exp_q.size()));
      for (int i = 0; i < MEM; i++)
        check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(exp_mem[i]));
    end
  endtask

  task automatic prog_test(input int max_cycles, input bit expect_halt, input bit chk_cycles);
    do_reset();
    model_run(100);
    run_prog(max_cycles, expect_halt, chk_cycles);
  endtask

  task automatic clear_img();
    for (int i = 0; i < MEM; i++) img[i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    run       = 1'b0;
    do_load   = 1'b0;
    ack_delay = 0;
    ack_rand  = 1'b0;
    stray_en  = 1'b0;
    clear_img();

    // Async reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_ac", 32'(ac_out), 32'd0);
    check("rst_z", 32'(flag_z), 32'd1);
    check("rst_c", 32'(flag_c), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Reference program, zero-wait and with 3-cycle acks.
    for (int pass = 0; pass < 2; pass++) begin
      ack_delay = (pass == 0) ? 0 : 3;
      clear_img();
      img[0] = 8'h0A; img[1] = 8'h4B; img[2] = 8'h2C; img[3] = 8'hE0;
      img[10] = 8'h05; img[11] = 8'h03;
      prog_test(200, 1'b1, 1'b1);
      check("ref_mem12", 32'(mem[12]), 32'h08);
      check("ref_ac", 32'(ac_out), 32'h08);
      check("ref_z", 32'(flag_z), 32'd0);
      check("ref_pc", 32'(pc_out), 32'd4);
    end
    ack_delay = 0;

    // Run ignored once halted.
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (4) @(negedge clk);
    check("sticky_halted", 32'(halted), 32'd1);
    check("sticky_req", 32'(mem_req), 32'd0);
    check("sticky_pc", 32'(pc_out), 32'd4);

    // Carry and zero from ADD wrap, then borrow from SUB.
    clear_img();
    img[0] = 8'h14; img[1] = 8'h55; img[2] = 8'hE0; img[20] = 8'hFF; img[21] = 8'h01;
    prog_test(200, 1'b1, 1'b1);
    check("add_ac", 32'(ac_out), 32'h00);
    check("add_c", 32'(flag_c), 32'd1);
    check("add_z", 32'(flag_z), 32'd1);
    img[2] = 8'h75; img[3] = 8'hE0;
    prog_test(200, 1'b1, 1'b1);
    check("sub_ac", 32'(ac_out), 32'hFF);
    check("sub_c", 32'(flag_c), 32'd1);
    check("sub_z", 32'(flag_z), 32'd0);

    // JZ taken and not taken.
    clear_img();
    img[0] = 8'h14; img[1] = 8'hA7; img[2] = 8'hE0; img[7] = 8'hE0; img[20] = 8'h00;
    prog_test(200, 1'b1, 1'b1);
    check("jz_taken_fetches", 32'(obs_addr.size() >= 4), 32'd1);
    if (obs_addr.size() >= 4) check("jz_taken_addr", 32'(obs_addr[3]), 32'd7);
    check("jz_taken_pc", 32'(pc_out), 32'd8);
    img[20] = 8'h01;
    prog_test(200, 1'b1, 1'b1);
    check("jz_not_fetches", 32'(obs_addr.size() >= 4), 32'd1);
    if (obs_addr.size() >= 4) check("jz_not_addr", 32'(obs_addr[3]), 32'd2);
    check("jz_not_pc", 32'(pc_out), 32'd3);

    // JMP to the last word, NOP there, PC wraps to 0.
    clear_img();
    img[0] = 8'h9F; img[31] = 8'hC0;
    prog_test(30, 1'b0, 1'b0);
    check("wrap_fetches", 32'(obs_addr.size() >= 3), 32'd1);
    if (obs_addr.size() >= 3) begin
      check("wrap_jmp_target", 32'(obs_addr[1]), 32'd31);
      check("wrap_addr", 32'(obs_addr[2]), 32'd0);
    end

    // Reset during a pending STA: transfer abandoned.
    clear_img();
    img[0] = 8'h0A; img[1] = 8'h2C; img[2] = 8'hE0; img[10] = 8'h05; img[12] = 8'h77;
    ack_delay = 5;
    do_reset();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    k = 0;
    while (k < 50 && !(mem_req && mem_we)) begin
      @(negedge clk);
      k++;
    end
    check("sta_reached", 32'(mem_req && mem_we), 32'd1);
    check("sta_ac", 32'(ac_out), 32'h05);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_pc", 32'(pc_out), 32'd0);
    check("midrst_ac", 32'(ac_out), 32'd0);
    check("midrst_z", 32'(flag_z), 32'd1);
    repeat (3) @(negedge clk);
    check("midrst_mem12", 32'(mem[12]), 32'h77);
    check("midrst_accesses", 32'(hs_cnt), 32'd3);
    ack_delay = 0;

    // Random forward-only programs with random/fixed ack delays and stray acks.
    stray_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      int op;
      ack_rand  = t[0];
      ack_delay = (t % 4 == 2) ? 2 : 0;
      for (int i = 0; i < 16; i++) begin
        op = int'($urandom_range(0, 6));
        if (op == 4 || op == 5) img[i] = 8'(op * 32 + int'($urandom_range(i + 1, 16)));
        else if (op < 4)        img[i] = 8'(op * 32 + int'($urandom_range(17, 31)));
        else                    img[i] = 8'(op * 32 + int'($urandom_range(0, 31)));
      end
      img[16] = 8'(224 + int'($urandom_range(0, 31)));
      for (int i = 17; i < MEM; i++) begin
        case ($urandom_range(0, 5))
          0:       img[i] = 8'h00;
          1:       img[i] = 8'hFF;
          default: img[i] = 8'($urandom);
        endcase
      end
      prog_test(2000, 1'b1, !ack_rand);
    end
    stray_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
